// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - SAP-1.5 fetch/decode/execute microstep sequencer
// Turns the IR opcode and ALU flags into the per-cycle control word.
module microsequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       flag_carry,
  input  logic       flag_zero,
  output logic       oe_pc,
  output logic       pc_enable,
  output logic       pc_load,
  output logic       load_mar,
  output logic       oe_ram,
  output logic       ram_we,
  output logic       load_ir,
  output logic       oe_ir,
  output logic       load_a,
  output logic       oe_a,
  output logic       load_b,
  output logic       oe_alu,
  output logic       subtract,
  output logic       flag_enable,
  output logic       load_out,
  output logic [2:0] microstep,
  output logic       halted
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [2:0] microstep_q, microstep_d;
  logic       halted_q, halted_d;
  logic       last_step;

  always_comb begin
    oe_pc       = 1'b0;
    pc_enable   = 1'b0;
    pc_load     = 1'b0;
    load_mar    = 1'b0;
    oe_ram      = 1'b0;
    ram_we      = 1'b0;
    load_ir     = 1'b0;
    oe_ir       = 1'b0;
    load_a      = 1'b0;
    oe_a        = 1'b0;
    load_b      = 1'b0;
    oe_alu      = 1'b0;
    subtract    = 1'b0;
    flag_enable = 1'b0;
    load_out    = 1'b0;
    last_step   = 1'b0;

    // Opcode is only trusted from T2 on; during T0/T1 the IR holds the old instruction.
    if (!reset && !halted_q) begin
      case (microstep_q)
        T0: begin
          oe_pc    = 1'b1;
          load_mar = 1'b1;
        end
        T1: begin
          oe_ram    = 1'b1;
          load_ir   = 1'b1;
          pc_enable = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              oe_ir    = 1'b1;
              load_mar = 1'b1;
            end
            OP_LDI: begin
              oe_ir     = 1'b1;
              load_a    = 1'b1;
              last_step = 1'b1;
            end
            OP_JMP: begin
              oe_ir     = 1'b1;
              pc_load   = 1'b1;
              last_step = 1'b1;
            end
            OP_JC: begin
              oe_ir     = 1'b1;
              pc_load   = flag_carry;
              last_step = 1'b1;
            end
            OP_JZ: begin
              oe_ir     = 1'b1;
              pc_load   = flag_zero;
              last_step = 1'b1;
            end
            OP_OUT: begin
              oe_a      = 1'b1;
              load_out  = 1'b1;
              last_step = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              oe_ram    = 1'b1;
              load_a    = 1'b1;
              last_step = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              oe_ram = 1'b1;
              load_b = 1'b1;
            end
            OP_STA: begin
              oe_a      = 1'b1;
              ram_we    = 1'b1;
              last_step = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            oe_alu      = 1'b1;
            load_a      = 1'b1;
            flag_enable = 1'b1;
            subtract    = (opcode == OP_SUB);
          end
          last_step = 1'b1;
        end
        default: last_step = 1'b1;
      endcase
    end
  end

  always_comb begin
    microstep_d = microstep_q;
    halted_d    = halted_q;
    if (reset) begin
      microstep_d = T0;
      halted_d    = 1'b0;
    end else if (halted_q) begin
      microstep_d = T0;
    end else if (last_step) begin
      microstep_d = T0;
      if (microstep_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end
    end else begin
      microstep_d = microstep_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      microstep_q <= T0;
      halted_q    <= 1'b0;
    end else begin
      microstep_q <= microstep_d;
      halted_q    <= halted_d;
    end
  end

  assign microstep = microstep_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - table-driven scoreboard bench for microsequencer
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       flag_carry, flag_zero;
  logic       oe_pc, pc_enable, pc_load, load_mar, oe_ram, ram_we, load_ir, oe_ir;
  logic       load_a, oe_a, load_b, oe_alu, subtract, flag_enable, load_out;
  logic [2:0] microstep;
  logic       halted;

  always #5 clk = ~clk;

  microsequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .oe_pc(oe_pc), .pc_enable(pc_enable), .pc_load(pc_load), .load_mar(load_mar),
    .oe_ram(oe_ram), .ram_we(ram_we), .load_ir(load_ir), .oe_ir(oe_ir),
    .load_a(load_a), .oe_a(oe_a), .load_b(load_b), .oe_alu(oe_alu),
    .subtract(subtract), .flag_enable(flag_enable), .load_out(load_out),
    .microstep(microstep), .halted(halted)
  );

  localparam logic [14:0] C_OE_PC  = 15'h4000;
  localparam logic [14:0] C_PC_EN  = 15'h2000;
  localparam logic [14:0] C_PC_LD  = 15'h1000;
  localparam logic [14:0] C_MAR    = 15'h0800;
  localparam logic [14:0] C_OE_RAM = 15'h0400;
  localparam logic [14:0] C_RAM_WE = 15'h0200;
  localparam logic [14:0] C_LD_IR  = 15'h0100;
  localparam logic [14:0] C_OE_IR  = 15'h0080;
  localparam logic [14:0] C_LD_A   = 15'h0040;
  localparam logic [14:0] C_OE_A   = 15'h0020;
  localparam logic [14:0] C_LD_B   = 15'h0010;
  localparam logic [14:0] C_OE_ALU = 15'h0008;
  localparam logic [14:0] C_SUB    = 15'h0004;
  localparam logic [14:0] C_FLAGEN = 15'h0002;
  localparam logic [14:0] C_LD_OUT = 15'h0001;
  localparam logic [14:0] F0 = C_OE_PC | C_MAR;
  localparam logic [14:0] F1 = C_OE_RAM | C_LD_IR | C_PC_EN;

  typedef struct packed {
    logic [2:0]  ms;
    logic [14:0] ctrl;
    logic        hlt;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic        fc;
    logic        fz;
    int          len;
    logic [14:0] w2, w3, w4;
  } vec_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_miss = 0;
  vec_t vecs[16];

  function automatic logic [14:0] ctrl_now();
    return {oe_pc, pc_enable, pc_load, load_mar, oe_ram, ram_we, load_ir, oe_ir,
            load_a, oe_a, load_b, oe_alu, subtract, flag_enable, load_out};
  endfunction

  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0100: return 4;
      4'b0010, 4'b0011: return 5;
      default:          return 3;
    endcase
  endfunction

  task automatic push(input logic [2:0] ms, input logic [14:0] c, input logic h);
    exp_t e;
    e.ms = ms; e.ctrl = c; e.hlt = h;
    sbq.push_back(e);
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are compared 2 units later.
  task automatic check_cycle(input string tag);
    exp_t e;
    #2;
    n_vec++;
    if (sbq.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, got ms=%0d ctrl=%h", tag, microstep, ctrl_now());
    end else begin
      e = sbq.pop_front();
      if (microstep !== e.ms || ctrl_now() !== e.ctrl || halted !== e.hlt) begin
        n_miss++;
        $display("FAIL %s op=%b: got ms=%0d ctrl=%h halted=%b, want ms=%0d ctrl=%h halted=%b",
                 tag, opcode, microstep, ctrl_now(), halted, e.ms, e.ctrl, e.hlt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    opcode = v.op; flag_carry = v.fc; flag_zero = v.fz;
    push(3'd0, F0, 1'b0);
    push(3'd1, F1, 1'b0);
    push(3'd2, v.w2, 1'b0);
    if (v.len > 3) push(3'd3, v.w3, 1'b0);
    if (v.len > 4) push(3'd4, v.w4, 1'b0);
    for (int i = 0; i < v.len; i++) check_cycle(tag);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic fc, input logic fz,
                              input int len, input logic [14:0] w2, input logic [14:0] w3,
                              input logic [14:0] w4);
    vec_t v;
    v.op = op; v.fc = fc; v.fz = fz; v.len = len; v.w2 = w2; v.w3 = w3; v.w4 = w4;
    return v;
  endfunction

  initial begin
    vec_t hv, ldi;
    int   cyc, oes;
    logic [3:0] rop;

    vecs[0]  = mk(4'b0101, 0, 0, 3, C_OE_IR | C_LD_A, 0, 0);
    vecs[1]  = mk(4'b0010, 0, 0, 5, C_OE_IR | C_MAR, C_OE_RAM | C_LD_B, C_OE_ALU | C_LD_A | C_FLAGEN);
    vecs[2]  = mk(4'b0011, 0, 0, 5, C_OE_IR | C_MAR, C_OE_RAM | C_LD_B,
                  C_OE_ALU | C_LD_A | C_FLAGEN | C_SUB);
    vecs[3]  = mk(4'b0111, 0, 1, 3, C_OE_IR, 0, 0);
    vecs[4]  = mk(4'b0111, 1, 0, 3, C_OE_IR | C_PC_LD, 0, 0);
    vecs[5]  = mk(4'b1000, 1, 0, 3, C_OE_IR, 0, 0);
    vecs[6]  = mk(4'b1000, 0, 1, 3, C_OE_IR | C_PC_LD, 0, 0);
    vecs[7]  = mk(4'b0100, 0, 0, 4, C_OE_IR | C_MAR, C_OE_A | C_RAM_WE, 0);
    vecs[8]  = mk(4'b1010, 1, 1, 3, 0, 0, 0);
    vecs[9]  = mk(4'b0001, 0, 0, 4, C_OE_IR | C_MAR, C_OE_RAM | C_LD_A, 0);
    vecs[10] = mk(4'b0000, 1, 1, 3, 0, 0, 0);
    vecs[11] = mk(4'b0110, 0, 0, 3, C_OE_IR | C_PC_LD, 0, 0);
    vecs[12] = mk(4'b1110, 0, 0, 3, C_OE_A | C_LD_OUT, 0, 0);
    vecs[13] = mk(4'b1001, 0, 0, 3, 0, 0, 0);
    vecs[14] = mk(4'b1101, 1, 0, 3, 0, 0, 0);
    vecs[15] = mk(4'b0011, 1, 1, 5, C_OE_IR | C_MAR, C_OE_RAM | C_LD_B,
                  C_OE_ALU | C_LD_A | C_FLAGEN | C_SUB);
    hv  = mk(4'b1111, 0, 0, 3, 0, 0, 0);
    ldi = vecs[0];

    reset = 1'b1; opcode = 4'b0101; flag_carry = 1'b0; flag_zero = 1'b0;
    @(posedge clk);
    #1;
    push(3'd0, 15'h0, 1'b0);
    check_cycle("reset");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // HLT, then 20 idle cycles, then reset releases it
    apply_vec(hv, "hlt");
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      push(3'd0, 15'h0, 1'b1);
      check_cycle("halted");
    end
    reset = 1'b1;
    push(3'd0, 15'h0, 1'b1);
    check_cycle("halt_reset");
    reset = 1'b0;
    apply_vec(ldi, "after_halt");

    // reset in T3 of ADD aborts it; fetch restarts at T0
    opcode = 4'b0010;
    push(3'd0, F0, 1'b0);
    push(3'd1, F1, 1'b0);
    push(3'd2, C_OE_IR | C_MAR, 1'b0);
    for (int i = 0; i < 3; i++) check_cycle("abort_pre");
    reset = 1'b1;
    push(3'd3, 15'h0, 1'b0);
    check_cycle("abort_rst");
    reset = 1'b0;
    apply_vec(ldi, "abort_post");

    // random program: bus contention and instruction length
    for (int k = 0; k < 1000; k++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop == 4'b1111) rop = 4'b0000;
      opcode = rop;
      flag_carry = 1'($urandom_range(0, 1));
      flag_zero  = 1'($urandom_range(0, 1));
      cyc = 0;
      do begin
        #2;
        oes = int'(oe_pc) + int'(oe_ram) + int'(oe_ir) + int'(oe_a) + int'(oe_alu);
        n_vec++;
        if (oes > 1) begin
          n_miss++;
          $display("FAIL bus_contention op=%b ms=%0d: got %0d drivers, want <=1", rop, microstep, oes);
        end
        @(posedge clk);
        #1;
        cyc++;
      end while (microstep != 3'd0 && cyc < 8);
      n_vec++;
      if (cyc != instr_len(rop)) begin
        n_miss++;
        $display("FAIL instr_len op=%b: got %0d cycles, want %0d", rop, cyc, instr_len(rop));
      end
    end

    n_vec++;
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d leftover, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
